// File: rtl/ecp5pll_pkg.sv
// Shared types and constants for the ECP5 PLL dynamic phase-shift sequencer.
package ecp5pll_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStepHi,
    StStepLo,
    StSettle,
    StWaitLock
  } phase_state_t;

  localparam logic PHASE_DIR_DELAY   = 1'b0;
  localparam logic PHASE_DIR_ADVANCE = 1'b1;

endpackage

// File: rtl/ecp5pll_phase_acc.sv
// Four signed per-output phase-step tallies with a +1/-1 update port and a
// combinational read mux.
module ecp5pll_phase_acc
  import ecp5pll_pkg::*;
#(
  parameter int unsigned ACC_W = 10
) (
  input  logic                    clk_i,
  input  logic                    reset,
  input  logic                    step_en,
  input  logic                    step_dir,
  input  logic [1:0]              step_sel,
  input  logic [1:0]              rd_sel,
  output logic signed [ACC_W-1:0] rd_val
);

  localparam logic signed [ACC_W-1:0] ONE = ACC_W'(1);

  logic signed [ACC_W-1:0] acc_q [4];

  // Two's-complement wrap at ACC_W is the natural overflow of the adder.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= '0;
      end
    end else if (step_en) begin
      if (step_dir == PHASE_DIR_ADVANCE) begin
        acc_q[step_sel] <= acc_q[step_sel] - ONE;
      end else begin
        acc_q[step_sel] <= acc_q[step_sel] + ONE;
      end
    end
  end

  assign rd_val = acc_q[rd_sel];

endmodule

// File: rtl/ecp5pll_phase_ctrl.sv
// Expands valid/ready phase-shift requests into timed PHASESEL/PHASEDIR/PHASESTEP
// activity, waits for PLL relock and keeps a per-output signed step tally.
module ecp5pll_phase_ctrl
  import ecp5pll_pkg::*;
#(
  parameter int unsigned STEPS_W      = 8,
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned STEP_HI_CYC  = 4,
  parameter int unsigned STEP_LO_CYC  = 4,
  parameter int unsigned SETTLE_CYC   = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned ACC_W        = 10
) (
  input  logic                    clk_i,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_sel,
  input  logic                    req_dir,
  input  logic [STEPS_W-1:0]      req_steps,
  output logic                    done,
  output logic                    err_timeout,
  output logic                    lock_lost,
  input  logic                    clr_flags,
  output logic                    busy,
  input  logic                    pll_locked,
  output logic [1:0]              pll_phasesel,
  output logic                    pll_phasedir,
  output logic                    pll_phasestep,
  output logic                    pll_phaseloadreg,
  input  logic [1:0]              acc_rd_sel,
  output logic signed [ACC_W-1:0] acc_rd_val
);

  localparam int unsigned MAX_AB  = (SETUP_CYC > STEP_HI_CYC) ? SETUP_CYC : STEP_HI_CYC;
  localparam int unsigned MAX_CD  = (STEP_LO_CYC > SETTLE_CYC) ? STEP_LO_CYC : SETTLE_CYC;
  localparam int unsigned MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned MAX_CYC = (MAX_ABCD > LOCK_TIMEOUT) ? MAX_ABCD : LOCK_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HI_LAST     = CNT_W'(STEP_HI_CYC - 1);
  localparam logic [CNT_W-1:0] LO_LAST     = CNT_W'(STEP_LO_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [STEPS_W-1:0] STEP_ONE  = STEPS_W'(1);

  if (STEPS_W == 0 || SETUP_CYC == 0 || STEP_HI_CYC == 0 || STEP_LO_CYC == 0 ||
      SETTLE_CYC == 0 || LOCK_TIMEOUT == 0 || ACC_W == 0) begin : g_param_check
    $error("ecp5pll_phase_ctrl: zero-valued parameters are not supported");
  end

  phase_state_t       state;
  logic [CNT_W-1:0]   cnt;
  logic [STEPS_W-1:0] steps_left;
  logic               req_accept;
  logic               step_exit;
  logic               timeout_hit;

  assign busy             = (state != StIdle);
  // The done cycle is already IDLE; holding ready low there keeps done and
  // acceptance in separate cycles.
  assign req_ready        = (state == StIdle) && !done;
  assign req_accept       = req_valid && req_ready;
  assign step_exit        = (state == StStepHi) && (cnt == HI_LAST);
  assign timeout_hit      = (state == StWaitLock) && !pll_locked && (cnt == TMO_LAST);
  assign pll_phaseloadreg = 1'b0;

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state         <= StIdle;
      cnt           <= '0;
      steps_left    <= '0;
      done          <= 1'b0;
      pll_phasesel  <= 2'd0;
      pll_phasedir  <= PHASE_DIR_DELAY;
      pll_phasestep <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (req_accept) begin
            pll_phasesel <= req_sel;
            pll_phasedir <= req_dir;
            steps_left   <= req_steps;
            cnt          <= '0;
            state        <= (req_steps == '0) ? StSettle : StSetup;
          end
        end
        StSetup: begin
          if (cnt == SETUP_LAST) begin
            cnt           <= '0;
            pll_phasestep <= 1'b1;
            state         <= StStepHi;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        StStepHi: begin
          if (step_exit) begin
            cnt           <= '0;
            pll_phasestep <= 1'b0;
            steps_left    <= steps_left - STEP_ONE;
            state         <= StStepLo;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        StStepLo: begin
          if (cnt == LO_LAST) begin
            cnt <= '0;
            if (steps_left != '0) begin
              pll_phasestep <= 1'b1;
              state         <= StStepHi;
            end else begin
              state <= StSettle;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        StSettle: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= StWaitLock;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        StWaitLock: begin
          if (pll_locked || timeout_hit) begin
            cnt   <= '0;
            done  <= 1'b1;
            state <= StIdle;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          cnt           <= '0;
          pll_phasestep <= 1'b0;
          state         <= StIdle;
        end
      endcase
    end
  end

  // Sticky flags: a set condition wins over a simultaneous clear.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      err_timeout <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end else if (clr_flags) begin
        err_timeout <= 1'b0;
      end
      if ((state == StIdle) && !pll_locked) begin
        lock_lost <= 1'b1;
      end else if (clr_flags) begin
        lock_lost <= 1'b0;
      end
    end
  end

  ecp5pll_phase_acc #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk_i    (clk_i),
    .reset    (reset),
    .step_en  (step_exit),
    .step_dir (pll_phasedir),
    .step_sel (pll_phasesel),
    .rd_sel   (acc_rd_sel),
    .rd_val   (acc_rd_val)
  );

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Randomized self-checking bench for ecp5pll_phase_ctrl against a cycle-count and
// tally model derived from the request timing rules.
module tb_ecp5pll_phase_ctrl;

  localparam int STEPS_W = 8;
  localparam int SETUP   = 2;
  localparam int HI      = 4;
  localparam int LO      = 4;
  localparam int SETTLE  = 16;
  localparam int TMO     = 100;
  localparam int ACC_W   = 10;

  logic               clk_i = 1'b0;
  logic               reset = 1'b1;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [1:0]         req_sel = 2'd0;
  logic               req_dir = 1'b0;
  logic [STEPS_W-1:0] req_steps = '0;
  logic               done;
  logic               err_timeout;
  logic               lock_lost;
  logic               clr_flags = 1'b0;
  logic               busy;
  logic               pll_locked = 1'b1;
  logic [1:0]         pll_phasesel;
  logic               pll_phasedir;
  logic               pll_phasestep;
  logic               pll_phaseloadreg;
  logic [1:0]         acc_rd_sel = 2'd0;
  logic [ACC_W-1:0]   acc_rd_val;

  int tests = 0;
  int fails = 0;
  int acc_m [4];

  ecp5pll_phase_ctrl #(
    .STEPS_W      (STEPS_W),
    .SETUP_CYC    (SETUP),
    .STEP_HI_CYC  (HI),
    .STEP_LO_CYC  (LO),
    .SETTLE_CYC   (SETTLE),
    .LOCK_TIMEOUT (TMO),
    .ACC_W        (ACC_W)
  ) dut (
    .clk_i            (clk_i),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_sel          (req_sel),
    .req_dir          (req_dir),
    .req_steps        (req_steps),
    .done             (done),
    .err_timeout      (err_timeout),
    .lock_lost        (lock_lost),
    .clr_flags        (clr_flags),
    .busy             (busy),
    .pll_locked       (pll_locked),
    .pll_phasesel     (pll_phasesel),
    .pll_phasedir     (pll_phasedir),
    .pll_phasestep    (pll_phasestep),
    .pll_phaseloadreg (pll_phaseloadreg),
    .acc_rd_sel       (acc_rd_sel),
    .acc_rd_val       (acc_rd_val)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int wrap_acc(input int v);
    int m;
    m = v % (1 << ACC_W);
    if (m < 0) m += (1 << ACC_W);
    if (m >= (1 << (ACC_W - 1))) m -= (1 << ACC_W);
    return m;
  endfunction

  // Acceptance-to-done cycles; lock_wait is 1 for immediate lock, TMO for timeout.
  function automatic int exp_lat(input int n, input int lock_wait);
    if (n == 0) return 1 + SETTLE + lock_wait;
    return 1 + SETUP + n * (HI + LO) + SETTLE + lock_wait;
  endfunction

  function automatic void model_req(input int s, input int d, input int n);
    acc_m[s] = wrap_acc(acc_m[s] + (d != 0 ? -n : n));
  endfunction

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic accept(input logic [1:0] s, input logic d, input int n, input bit hold);
    int w;
    w = 0;
    while (req_ready !== 1'b1 && w < 200) begin
      @(negedge clk_i);
      w++;
    end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL accept_ready: req_ready=%b, expected 1", req_ready);
    end
    req_valid = 1'b1;
    req_sel   = s;
    req_dir   = d;
    req_steps = n[STEPS_W-1:0];
    @(negedge clk_i);
    if (!hold) req_valid = 1'b0;
  endtask

  // Follows one request until done; first sample is the current negedge.
  task automatic monitor(input logic [1:0] s, input logic d, input int bound,
                         output int lat, output int pulses, output int first_pulse,
                         output int errs);
    int hi_run;
    int lo_run;
    logic prev;
    lat = -1; pulses = 0; first_pulse = -1; errs = 0;
    hi_run = 0; lo_run = 0; prev = 1'b0;
    for (int cyc = 1; cyc <= bound; cyc++) begin
      if (cyc > 1) @(negedge clk_i);
      if (pll_phasesel !== s || pll_phasedir !== d || pll_phaseloadreg !== 1'b0 ||
          req_ready !== 1'b0) errs++;
      if (pll_phasestep === 1'b1) begin
        if (!prev) begin
          pulses++;
          if (first_pulse < 0) first_pulse = cyc;
          if (pulses > 1 && lo_run != LO) errs++;
          hi_run = 0;
        end
        hi_run++;
      end else begin
        if (prev) begin
          if (hi_run != HI) errs++;
          lo_run = 0;
        end
        lo_run++;
      end
      prev = pll_phasestep;
      if (done === 1'b1) begin
        lat = cyc;
        if (busy !== 1'b0 || prev) errs++;
        break;
      end else if (busy !== 1'b1) begin
        errs++;
      end
    end
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    repeat (3) @(negedge clk_i);
    obs = {req_ready, done, busy, err_timeout, lock_lost, pll_phasesel, pll_phasedir,
           pll_phasestep, pll_phaseloadreg};
    tests++;
    if (obs !== 10'b1_0_0_0_0_00_0_0_0) begin
      fails++;
      $display("FAIL reset_outputs: got %b, expected %b", obs, 10'b1000000000);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) acc_m[i] = 0;
    @(negedge clk_i);
    obs = {req_ready, done, busy, err_timeout, lock_lost, pll_phasesel, pll_phasedir,
           pll_phasestep, pll_phaseloadreg};
    tests++;
    if (obs !== 10'b1_0_0_0_0_00_0_0_0) begin
      fails++;
      $display("FAIL post_reset_idle: got %b, expected %b", obs, 10'b1000000000);
    end
    for (int i = 0; i < 4; i++) begin
      acc_rd_sel = 2'(i);
      #1;
      tests++;
      if (int'($signed(acc_rd_val)) !== 0) begin
        fails++;
        $display("FAIL reset_acc%0d: got %0d, expected 0", i, $signed(acc_rd_val));
      end
    end
  endtask

  // One request with immediate lock; checks timing, pulse shape and all tallies.
  task automatic run_checked(input string name, input logic [1:0] s, input logic d,
                             input int n, input bit check_first);
    int lat, pulses, first, errs;
    accept(s, d, n, 1'b0);
    model_req(s, d, n);
    monitor(s, d, exp_lat(n, 1) + 20, lat, pulses, first, errs);
    tests++;
    if (lat !== exp_lat(n, 1)) begin
      fails++;
      $display("FAIL %s_latency: got %0d, expected %0d", name, lat, exp_lat(n, 1));
    end
    tests++;
    if (pulses !== n) begin
      fails++;
      $display("FAIL %s_pulses: got %0d, expected %0d", name, pulses, n);
    end
    tests++;
    if (errs !== 0) begin
      fails++;
      $display("FAIL %s_shape: got %0d violations, expected 0", name, errs);
    end
    if (check_first) begin
      tests++;
      if (first !== 1 + SETUP) begin
        fails++;
        $display("FAIL %s_first_pulse: got cycle %0d, expected %0d", name, first, 1 + SETUP);
      end
    end
    for (int i = 0; i < 4; i++) begin
      acc_rd_sel = 2'(i);
      #1;
      tests++;
      if (int'($signed(acc_rd_val)) !== acc_m[i]) begin
        fails++;
        $display("FAIL %s_acc%0d: got %0d, expected %0d", name, i, $signed(acc_rd_val),
                 acc_m[i]);
      end
    end
  endtask

  task automatic test_basic();
    run_checked("basic", 2'd1, 1'b0, 3, 1'b1);
  endtask

  task automatic test_zero_steps();
    run_checked("zero", 2'd2, 1'b1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      run_checked("rand", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 12)), 1'b0);
    end
  endtask

  task automatic test_timeout();
    int lat, pulses, first, errs;
    logic [1:0] s;
    logic d;
    s = 2'($urandom_range(0, 3));
    d = 1'($urandom_range(0, 1));
    accept(s, d, 1, 1'b0);
    model_req(s, d, 1);
    pll_locked = 1'b0;
    monitor(s, d, exp_lat(1, TMO) + 20, lat, pulses, first, errs);
    tests++;
    if (lat !== exp_lat(1, TMO)) begin
      fails++;
      $display("FAIL timeout_latency: got %0d, expected %0d", lat, exp_lat(1, TMO));
    end
    tests++;
    if (err_timeout !== 1'b1) begin
      fails++;
      $display("FAIL timeout_flag: got %b, expected 1", err_timeout);
    end
    pll_locked = 1'b1;
    @(negedge clk_i);
    tests++;
    if ({err_timeout, lock_lost} !== 2'b10) begin
      fails++;
      $display("FAIL timeout_sticky: got %b, expected 10", {err_timeout, lock_lost});
    end
    clr_flags = 1'b1;
    @(negedge clk_i);
    clr_flags = 1'b0;
    tests++;
    if (err_timeout !== 1'b0) begin
      fails++;
      $display("FAIL timeout_clear: got %b, expected 0", err_timeout);
    end
  endtask

  task automatic test_back_to_back();
    int lat, pulses, first, errs;
    logic [1:0] sa, sb;
    logic da, db;
    int na, nb;
    sa = 2'($urandom_range(0, 3)); da = 1'($urandom_range(0, 1)); na = int'($urandom_range(1, 4));
    sb = 2'($urandom_range(0, 3)); db = 1'($urandom_range(0, 1)); nb = int'($urandom_range(1, 4));
    accept(sa, da, na, 1'b1);
    model_req(sa, da, na);
    req_sel = sb; req_dir = db; req_steps = nb[STEPS_W-1:0];
    monitor(sa, da, exp_lat(na, 1) + 20, lat, pulses, first, errs);
    tests++;
    if (lat !== exp_lat(na, 1) || pulses !== na || errs !== 0) begin
      fails++;
      $display("FAIL b2b_first: got lat=%0d pulses=%0d errs=%0d, expected %0d %0d 0",
               lat, pulses, errs, exp_lat(na, 1), na);
    end
    @(negedge clk_i);
    tests++;
    if ({req_ready, busy, done} !== 3'b100) begin
      fails++;
      $display("FAIL b2b_ready_after_done: got %b, expected 100", {req_ready, busy, done});
    end
    @(negedge clk_i);
    req_valid = 1'b0;
    model_req(sb, db, nb);
    monitor(sb, db, exp_lat(nb, 1) + 20, lat, pulses, first, errs);
    tests++;
    if (lat !== exp_lat(nb, 1) || pulses !== nb || errs !== 0) begin
      fails++;
      $display("FAIL b2b_second: got lat=%0d pulses=%0d errs=%0d, expected %0d %0d 0",
               lat, pulses, errs, exp_lat(nb, 1), nb);
    end
    for (int i = 0; i < 4; i++) begin
      acc_rd_sel = 2'(i);
      #1;
      tests++;
      if (int'($signed(acc_rd_val)) !== acc_m[i]) begin
        fails++;
        $display("FAIL b2b_acc%0d: got %0d, expected %0d", i, $signed(acc_rd_val), acc_m[i]);
      end
    end
  endtask

  task automatic test_lock_lost();
    @(negedge clk_i);
    tests++;
    if (lock_lost !== 1'b0) begin
      fails++;
      $display("FAIL lock_lost_initial: got %b, expected 0", lock_lost);
    end
    pll_locked = 1'b0;
    @(negedge clk_i);
    pll_locked = 1'b1;
    repeat (5) @(negedge clk_i);
    tests++;
    if (lock_lost !== 1'b1) begin
      fails++;
      $display("FAIL lock_lost_sticky: got %b, expected 1", lock_lost);
    end
    clr_flags = 1'b1;
    pll_locked = 1'b0;
    @(negedge clk_i);
    tests++;
    if (lock_lost !== 1'b1) begin
      fails++;
      $display("FAIL lock_lost_set_wins: got %b, expected 1", lock_lost);
    end
    pll_locked = 1'b1;
    @(negedge clk_i);
    clr_flags = 1'b0;
    tests++;
    if (lock_lost !== 1'b0) begin
      fails++;
      $display("FAIL lock_lost_clear: got %b, expected 0", lock_lost);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] obs;
    int w;
    accept(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5, 1'b0);
    w = 0;
    while (pll_phasestep !== 1'b1 && w < 50) begin
      @(negedge clk_i);
      w++;
    end
    repeat (9) @(negedge clk_i);  // into the second pulse's high phase
    tests++;
    if (pll_phasestep !== 1'b1) begin
      fails++;
      $display("FAIL midreset_reach_step_hi: got phasestep=%b, expected 1", pll_phasestep);
    end
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) acc_m[i] = 0;
    obs = {req_ready, done, busy, err_timeout, lock_lost, pll_phasesel, pll_phasedir,
           pll_phasestep, pll_phaseloadreg};
    tests++;
    if (obs !== 10'b1_0_0_0_0_00_0_0_0) begin
      fails++;
      $display("FAIL midreset_outputs: got %b, expected %b", obs, 10'b1000000000);
    end
    for (int i = 0; i < 4; i++) begin
      acc_rd_sel = 2'(i);
      #1;
      tests++;
      if (int'($signed(acc_rd_val)) !== acc_m[i]) begin
        fails++;
        $display("FAIL midreset_acc%0d: got %0d, expected 0", i, $signed(acc_rd_val));
      end
    end
    @(negedge clk_i);
    reset = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_wrap();
    // 600 delay steps on output 0, split to fit the request width
    run_checked("wrap_a", 2'd0, 1'b0, 255, 1'b0);
    run_checked("wrap_b", 2'd0, 1'b0, 255, 1'b0);
    run_checked("wrap_c", 2'd0, 1'b0, 90, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_steps();
    test_timeout();
    test_back_to_back();
    test_random();
    test_lock_lost();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ecp5pll_phase_ctrl.md
Name: ecp5pll_phase_ctrl

Overview:
Sequencer for the dynamic phase-shift port of the ECP5 PLL wrapper. It accepts phase-shift requests over a valid/ready handshake and expands each into correctly timed PHASESEL/PHASEDIR/PHASESTEP activity. It then waits for PLL lock and keeps a per-output signed phase-step tally. It sits between the SDRAM/memtest calibration logic and the PLL instance built with dynamic_en=1.

Parameters:
STEPS_W, 8, width of the request step count
SETUP_CYC, 2, cycles that sel/dir are held stable before the first step pulse
STEP_HI_CYC, 4, high time of each phasestep pulse, in clocks
STEP_LO_CYC, 4, low time after each pulse before the next pulse
SETTLE_CYC, 16, cycles to wait after the last pulse before sampling lock
LOCK_TIMEOUT, 65535, maximum cycles to wait for pll_locked after settling
ACC_W, 10, width of each per-channel signed phase accumulator

Ports:
clk_i  in  1  system clock (same domain as the PLL dynamic-phase inputs)
reset  in  1  asynchronous, active-high reset
req_valid  in  1  phase-shift request valid
req_ready  out  1  controller can accept a request
req_sel  in  2  output index 0..3 (clk_o[0]=CLKOP .. clk_o[3]=CLKOS3), passed through to the PLL phasesel
req_dir  in  1  0 = delay (+1 per step), 1 = advance (-1 per step)
req_steps  in  STEPS_W  number of phase steps; 0 is legal
done  out  1  one-cycle pulse when a request completes
err_timeout  out  1  sticky; set when lock is not regained within LOCK_TIMEOUT
lock_lost  out  1  sticky; set when pll_locked is low while IDLE
clr_flags  in  1  clears err_timeout and lock_lost
busy  out  1  high in every state except IDLE
pll_locked  in  1  LOCK output of the PLL (treated as synchronous to clk_i)
pll_phasesel  out  2  to PLL phasesel
pll_phasedir  out  1  to PLL phasedir
pll_phasestep  out  1  to PLL phasestep
pll_phaseloadreg  out  1  to PLL phaseloadreg; held 0
acc_rd_sel  in  2  accumulator read index
acc_rd_val  out  ACC_W  signed tally for the selected channel (combinational read)

Behaviour:
- Reset values: state IDLE; req_ready=1; done=0; busy=0; err_timeout=0; lock_lost=0; pll_phasesel=0; pll_phasedir=0; pll_phasestep=0; pll_phaseloadreg=0; all accumulators 0; all counters 0.
- FSM states: IDLE, SETUP, STEP_HI, STEP_LO, SETTLE, WAIT_LOCK.
- IDLE, req_ready=1. A request is accepted when req_valid && req_ready. On acceptance:
  - latch sel, dir and steps;
  - drive pll_phasesel=req_sel and pll_phasedir=req_dir on the next edge;
  - go to SETUP;
  - if steps==0, go to SETTLE instead.
- SETUP: hold for SETUP_CYC cycles, then go to STEP_HI.
- STEP_HI: pll_phasestep=1 for STEP_HI_CYC cycles. On exit:
  - decrement the remaining-step counter;
  - add +1 (dir 0) or -1 (dir 1) to acc[sel], two's-complement wrap at ACC_W;
  - go to STEP_LO.
- STEP_LO: pll_phasestep=0 for STEP_LO_CYC cycles. Then go to STEP_HI if remaining>0, else SETTLE.
- SETTLE: wait SETTLE_CYC cycles, then go to WAIT_LOCK.
- WAIT_LOCK: count cycles.
  - pll_locked=1: pulse done, go to IDLE.
  - Count reaches LOCK_TIMEOUT without lock: set err_timeout, pulse done, go to IDLE.
- pll_phasesel and pll_phasedir stay constant from SETUP through WAIT_LOCK. They keep their last value in IDLE.
- req_ready=0 in every non-IDLE state, so new requests are back-pressured. A request with req_valid held is accepted on the first IDLE cycle. done and acceptance may occur on consecutive cycles but never in the same cycle.
- Latency for N>0 steps, acceptance to done with immediate lock: 1+SETUP_CYC+N*(STEP_HI_CYC+STEP_LO_CYC)+SETTLE_CYC+1 cycles. With defaults and N=3 this is 44.
- Lock monitor: pll_locked==0 in IDLE sets lock_lost. Lock state during shifting is not flagged.
- clr_flags clears both flags. If a set condition occurs in the same cycle, set wins.
- Asynchronous reset mid-operation forces pll_phasestep low immediately and returns to IDLE. Accumulators clear to 0, which may no longer match the PLL; software must re-calibrate.
- Counters are sized to clog2 of the largest parameter plus 1. Parameter values of 0 are illegal and rejected at elaboration.

Decomposition:
- Shared package ecp5pll_pkg: state enum phase_state_t, and constants PHASE_DIR_DELAY=0 / PHASE_DIR_ADVANCE=1.
- One sub-module, ecp5pll_phase_acc: four ACC_W signed registers with increment/decrement port, async reset, and combinational read mux.

Test Plan:
- Request sel=1, dir=0, steps=3, pll_locked=1 -> exactly 3 phasestep pulses, each 4 high / 4 low; phasesel=1 stable from 2 cycles before the first pulse; done 44 cycles after acceptance; acc[1]=+3.
- Request sel=2, dir=1, steps=0 -> no phasestep pulses; done after 18 cycles; acc[2]=0.
- Hold pll_locked=0 through WAIT_LOCK with LOCK_TIMEOUT=100 -> err_timeout=1 and a done pulse; clr_flags pulse -> err_timeout=0.
- req_valid held high with two back-to-back requests -> req_ready=0 while busy; second request accepted the cycle after done; pulse counts match each request.
- Assert reset during STEP_HI of a 5-step request -> phasestep drops within the reset cycle; all outputs at reset values; acc all 0.
- Deassert pll_locked for 1 cycle while IDLE -> lock_lost=1 and stays set until clr_flags; 600 steps dir=0 on sel=0 -> acc[0] wraps to 600-1024=-424.
